// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM pipeline: ALU command encodings, the decoded
// control bundle carried between stages, and the register-match helper.
package arm_pipe_pkg;

   localparam logic [3:0] ALU_NOP = 4'b0000;
   localparam logic [3:0] ALU_MOV = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_ADC = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_SBC = 4'b0101;
   localparam logic [3:0] ALU_AND = 4'b0110;
   localparam logic [3:0] ALU_ORR = 4'b0111;
   localparam logic [3:0] ALU_EOR = 4'b1000;
   localparam logic [3:0] ALU_MVN = 4'b1001;

   localparam logic [3:0] REG_PC = 4'd15;

   typedef struct packed {
      logic [3:0] alu_command;
      logic       mem_read;
      logic       mem_write;
      logic       wb_en;
      logic       branch;
      logic       status_en;
   } ctrl_t;

   // A bubble has every control bit clear and the NOP command.
   localparam ctrl_t CTRL_BUBBLE = '{alu_command: ALU_NOP, default: 1'b0};

   // True when the instruction in ID reads register dest.
   function automatic logic reg_match(input logic       src1_valid,
                                      input logic [3:0] src1,
                                      input logic       two_src,
                                      input logic [3:0] src2,
                                      input logic [3:0] dest);
      return (src1_valid && (src1 == dest)) || (two_src && (src2 == dest));
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// RAW hazard check for the instruction in ID. With FORWARDING_EN defined only
// load-use against EX stalls; otherwise any pending write in EX or MEM stalls.
module hazard_detect
   import arm_pipe_pkg::*;
(
   input  logic [3:0] id_src1,
   input  logic       id_src1_valid,
   input  logic [3:0] id_src2,
   input  logic       id_two_src,
   input  logic [3:0] ex_dest,
   input  logic       ex_wb_en,
   input  logic       ex_mem_read,
   input  logic [3:0] mem_dest,
   input  logic       mem_wb_en,
   output logic       hazard
);

   logic ex_hit;
   logic mem_hit;

   assign ex_hit  = ex_wb_en  & reg_match(id_src1_valid, id_src1, id_two_src, id_src2, ex_dest);
   assign mem_hit = mem_wb_en & reg_match(id_src1_valid, id_src1, id_two_src, id_src2, mem_dest);

`ifdef FORWARDING_EN
   // MEM results and non-load EX results are bypassed, so only load-use waits.
   logic unused_mem_hit;
   assign unused_mem_hit = mem_hit;
   assign hazard = ex_hit & ex_mem_read;
`else
   logic unused_ex_mem_read;
   assign unused_ex_mem_read = ex_mem_read;
   assign hazard = ex_hit | mem_hit;
`endif

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with bubble insertion, flush, freeze and a saturating
// stall counter. Define FORWARDING_EN for load-use-only hazards plus ex_src1/ex_src2.
module id_ex_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              freeze,
   input  logic              flush,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [DATA_W-1:0] id_val_rn,
   input  logic [DATA_W-1:0] id_val_rm,
   input  logic [11:0]       id_shift_operand,
   input  logic              id_imm,
   input  logic [23:0]       id_signed_imm24,
   input  logic [3:0]        id_dest,
   input  logic [3:0]        id_src1,
   input  logic [3:0]        id_src2,
   input  logic              id_src1_valid,
   input  logic              id_two_src,
   input  logic [3:0]        id_alu_command,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_wb_en,
   input  logic              id_branch,
   input  logic              id_status_en,
   input  logic              id_carry,
   input  logic [3:0]        mem_dest,
   input  logic              mem_wb_en,
   output logic [DATA_W-1:0] ex_pc,
   output logic [DATA_W-1:0] ex_val_rn,
   output logic [DATA_W-1:0] ex_val_rm,
   output logic [11:0]       ex_shift_operand,
   output logic              ex_imm,
   output logic [23:0]       ex_signed_imm24,
   output logic [3:0]        ex_dest,
`ifdef FORWARDING_EN
   output logic [3:0]        ex_src1,
   output logic [3:0]        ex_src2,
`endif
   output logic [3:0]        ex_alu_command,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_wb_en,
   output logic              ex_branch,
   output logic              ex_status_en,
   output logic              ex_carry,
   output logic              hazard_stall,
   output logic [CNT_W-1:0]  stall_count
);

   import arm_pipe_pkg::*;

   ctrl_t ex_ctrl;
   ctrl_t id_ctrl;
   logic  hazard;

   assign id_ctrl = '{alu_command: id_alu_command, mem_read: id_mem_read,
                      mem_write: id_mem_write, wb_en: id_wb_en,
                      branch: id_branch, status_en: id_status_en};

   assign ex_alu_command = ex_ctrl.alu_command;
   assign ex_mem_read    = ex_ctrl.mem_read;
   assign ex_mem_write   = ex_ctrl.mem_write;
   assign ex_wb_en       = ex_ctrl.wb_en;
   assign ex_branch      = ex_ctrl.branch;
   assign ex_status_en   = ex_ctrl.status_en;

   hazard_detect u_hazard_detect (
      .id_src1      (id_src1),
      .id_src1_valid(id_src1_valid),
      .id_src2      (id_src2),
      .id_two_src   (id_two_src),
      .ex_dest      (ex_dest),
      .ex_wb_en     (ex_ctrl.wb_en),
      .ex_mem_read  (ex_ctrl.mem_read),
      .mem_dest     (mem_dest),
      .mem_wb_en    (mem_wb_en),
      .hazard       (hazard)
   );

   // Deliberately not gated by freeze: the front end must keep holding.
   assign hazard_stall = hazard & ~flush;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_ctrl          <= CTRL_BUBBLE;
         ex_pc            <= '0;
         ex_val_rn        <= '0;
         ex_val_rm        <= '0;
         ex_shift_operand <= '0;
         ex_imm           <= 1'b0;
         ex_signed_imm24  <= '0;
         ex_dest          <= '0;
         ex_carry         <= 1'b0;
`ifdef FORWARDING_EN
         ex_src1          <= '0;
         ex_src2          <= '0;
`endif
         stall_count      <= '0;
      end else if (!freeze) begin
         if (flush || hazard) begin
            ex_ctrl          <= CTRL_BUBBLE;
            ex_pc            <= '0;
            ex_val_rn        <= '0;
            ex_val_rm        <= '0;
            ex_shift_operand <= '0;
            ex_imm           <= 1'b0;
            ex_signed_imm24  <= '0;
            ex_dest          <= '0;
            ex_carry         <= 1'b0;
`ifdef FORWARDING_EN
            ex_src1          <= '0;
            ex_src2          <= '0;
`endif
            if (!flush && (stall_count != {CNT_W{1'b1}}))
               stall_count <= stall_count + CNT_W'(1);
         end else begin
            ex_ctrl          <= id_ctrl;
            ex_pc            <= id_pc;
            ex_val_rn        <= id_val_rn;
            ex_val_rm        <= id_val_rm;
            ex_shift_operand <= id_shift_operand;
            ex_imm           <= id_imm;
            ex_signed_imm24  <= id_signed_imm24;
            ex_dest          <= id_dest;
            ex_carry         <= id_carry;
`ifdef FORWARDING_EN
            ex_src1          <= id_src1;
            ex_src2          <= id_src2;
`endif
         end
      end
   end

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline boundary of the 5-stage ARM core. Captures the decoded control bundle (ALU command, mem_read, mem_write, wb_en, branch, status_en) plus operands from the ID stage each cycle and presents them to EX. It owns hazard detection for the instruction currently in ID: it inserts bubbles into EX and asserts a stall back to PC/IF-ID. It also handles branch flush and global freeze, and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- DATA_W, 32, operand/PC width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- freeze  in  1  global hold (memory wait); all state holds
- flush  in  1  branch taken in EX; kill instruction entering EX
- id_pc, id_val_rn, id_val_rm  in  DATA_W  PC+4 and register operands
- id_shift_operand  in  12  shifter operand field
- id_imm  in  1  immediate flag
- id_signed_imm24  in  24  branch offset
- id_dest, id_src1, id_src2  in  4  destination and source register indices
- id_src1_valid  in  1  instruction reads Rn
- id_two_src  in  1  instruction reads Rm (register operand or STR)
- id_alu_command  in  4  ALU command from control unit
- id_mem_read, id_mem_write, id_wb_en, id_branch, id_status_en  in  1 each  control bits
- id_carry  in  1  status C flag sampled in ID
- mem_dest  in  4  destination of instruction in MEM
- mem_wb_en  in  1  MEM instruction writes back
- ex_* (one per id_* input above except src valid flags)  out  matching width  registered copies
- hazard_stall  out  1  hold PC and IF/ID this cycle
- stall_count  out  CNT_W  cycles in which a hazard bubble was inserted

## Operation
- Register update priority each edge: freeze > flush > hazard bubble > normal load.
- freeze=1: every register, including stall_count, holds. flush is ignored, and EX re-asserts it next cycle.
- flush=1 (no freeze): load bubble. All ex_ control bits = 0, ex_alu_command = 4'b0000, and datapath fields = 0.
- hazard (no freeze, no flush): load bubble; stall_count increments, saturating at all-ones.
- Otherwise: every ex_ output loads its id_ counterpart.
- hazard_stall = hazard & ~flush. It is combinational and not gated by freeze.
- Match definition: (id_src1_valid & id_src1==D) | (id_two_src & id_src2==D).
- hazard without forwarding: match on ex_dest with ex_wb_en, or match on mem_dest with mem_wb_en.
- hazard with forwarding: see Configuration.
- A bubble in EX has ex_wb_en=0, so it never causes a hazard.

## Timing
- Reset (async assert, sync-released by system): all ex_ outputs 0, stall_count 0.
- hazard_stall is 0 whenever flush=1 or both wb_en sources are 0.
- Latency: ID→EX one cycle.
- A stalled instruction stays in ID and is re-evaluated every cycle until the hazard clears. There is no internal state machine for this; it is fully re-decoded each cycle.
- Simultaneous flush and hazard: bubble is inserted, hazard_stall=0, stall_count unchanged.
- Reset mid-stall: outputs cleared immediately and stall_count cleared; hazard_stall recomputes from the cleared ex_ state.

## Configuration
- FORWARDING_EN defined:
  - hazard = ex_mem_read & ex_wb_en & match(ex_dest) (load-use only).
  - ex_src1/ex_src2 outputs (4 bits each) are added for the EX forwarding unit.
- FORWARDING_EN undefined:
  - The full RAW check against both EX and MEM applies.
  - ex_src1/ex_src2 ports are absent.

## Structure
- Shared package arm_pipe_pkg:
  - ALU command constants: MOV 0001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, MVN 1001, NOP 0000.
  - ctrl_t packed struct holding the five control bits plus the ALU command.
  - REG_PC = 4'd15.
- One combinational sub-module, hazard_detect, computes hazard from id/ex/mem fields; FORWARDING_EN selects its equation. The register and counter logic stays in the top.

## Test plan
- Reset then load ADD (cmd 0010, wb_en=1, dest=3): ex_alu_command=0010 and ex_wb_en=1 one cycle later; hazard_stall=0.
- No forwarding: EX holds dest=3 wb_en=1; ID reads src1=3 → hazard_stall=1, EX bubble, stall_count=1. Next cycle the instruction is in MEM (mem_dest=3) → stall again, count=2. Then it releases.
- FORWARDING_EN, same sequence: no stall. Then LDR (mem_read=1, dest=5) in EX with ID SUB src2=5, two_src=1 → exactly one stall cycle, count=1.
- flush=1 together with a pending hazard: EX gets a bubble, hazard_stall=0, count unchanged.
- freeze=1 for 3 cycles with flush and hazard active: ex_ outputs and stall_count unchanged throughout.
- Force stall_count to all-ones via long stall, then one more hazard: count stays 0xFFFF. Async rst_n low mid-cycle: outputs clear without a clock edge.
